// File: rtl/ext_trig_cond_if.sv
// Bundle of ext_trig_cond signals: raw trigger inputs, configuration, the
// accepted-trigger strobe and the housekeeping counters.
// The master modport drives the inputs; the slave modport is the conditioner.
interface ext_trig_cond_if #(
  parameter int MW_W  = 8,
  parameter int HO_W  = 16,
  parameter int CNT_W = 32
);
  logic             ext_trig_maroc;
  logic             pixel_trig_maroc;
  logic             trig_en;
  logic             self_mask_en;
  logic [MW_W-1:0]  min_width;
  logic [HO_W-1:0]  holdoff;
  logic             cnt_clr;
  logic             trig_pulse;
  logic             trig_is_self;
  logic             trig_busy;
  logic [CNT_W-1:0] trig_count;
  logic [CNT_W-1:0] self_count;
  logic [15:0]      glitch_count;
  logic [47:0]      trig_ts;

  modport master (
    output ext_trig_maroc, pixel_trig_maroc, trig_en, self_mask_en,
           min_width, holdoff, cnt_clr,
    input  trig_pulse, trig_is_self, trig_busy, trig_count, self_count,
           glitch_count, trig_ts
  );

  modport slave (
    input  ext_trig_maroc, pixel_trig_maroc, trig_en, self_mask_en,
           min_width, holdoff, cnt_clr,
    output trig_pulse, trig_is_self, trig_busy, trig_count, self_count,
           glitch_count, trig_ts
  );
endinterface

// File: rtl/ext_trig_cond.sv
// External trigger conditioner: synchronises the shared trigger line,
// qualifies pulses by minimum width, classifies self/external origin,
// applies a holdoff and emits a one-cycle accepted-trigger strobe.
// Optional feature: define EXT_TRIG_TIMESTAMP_EN to timestamp each fire
// with a free-running 48-bit counter; otherwise trig_ts is tied to 0.
module ext_trig_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int MW_W        = 8,
  parameter int HO_W        = 16,
  parameter int CNT_W       = 32
) (
  input logic           clk,
  input logic           rst_n,
  ext_trig_cond_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_QUAL = 3'd1;
  localparam logic [2:0] S_FIRE = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_WLOW = 3'd4;

  localparam logic [MW_W-1:0]  MW_ONE  = 1;
  localparam logic [HO_W-1:0]  HO_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [SYNC_STAGES-1:0] s_sync, p_sync;
  logic                   s, p;

  logic [2:0]       state, state_nxt;
  logic [MW_W-1:0]  wcnt, wcnt_nxt, mw_q, mw_nxt;
  logic [HO_W-1:0]  ho_cnt, ho_nxt;
  logic             self_f, self_nxt;
  logic             fire_entry, glitch_inc;

  logic             trig_pulse_q, trig_is_self_q, trig_busy_q;
  logic [CNT_W-1:0] trig_count_q, self_count_q;
  logic [15:0]      glitch_count_q;

  assign s = s_sync[SYNC_STAGES-1];
  assign p = p_sync[SYNC_STAGES-1];

  // Synchronise the line and delay the local drive by the same depth.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      s_sync <= '0;
      p_sync <= '0;
    end else begin
      s_sync <= {s_sync[SYNC_STAGES-2:0], bus.ext_trig_maroc};
      p_sync <= {p_sync[SYNC_STAGES-2:0], bus.pixel_trig_maroc};
    end
  end

  // Next-state and datapath decode for the conditioning FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    mw_nxt     = mw_q;
    self_nxt   = self_f;
    ho_nxt     = ho_cnt;
    fire_entry = 1'b0;
    glitch_inc = 1'b0;
    case (state)
      S_IDLE: if (s) begin
        state_nxt = S_QUAL;
        wcnt_nxt  = MW_ONE;
        mw_nxt    = (bus.min_width == '0) ? MW_ONE : bus.min_width;
        self_nxt  = p;
      end
      S_QUAL: begin
        self_nxt = self_f | p;
        if (wcnt == mw_q) begin
          state_nxt  = S_FIRE;
          fire_entry = 1'b1;
        end else if (!s) begin
          state_nxt  = S_IDLE;
          glitch_inc = 1'b1;
        end else begin
          wcnt_nxt = wcnt + MW_ONE;
        end
      end
      S_FIRE: begin
        if (bus.holdoff == '0) begin
          state_nxt = S_WLOW;
        end else begin
          state_nxt = S_HOLD;
          ho_nxt    = bus.holdoff;
        end
      end
      S_HOLD: begin
        if (ho_cnt <= HO_ONE) state_nxt = S_WLOW;
        else                  ho_nxt    = ho_cnt - HO_ONE;
      end
      S_WLOW: if (!s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Disable aborts whatever is in flight; an aborted qualification is
    // neither a fire nor a glitch.
    if (!bus.trig_en) begin
      state_nxt  = S_IDLE;
      fire_entry = 1'b0;
      glitch_inc = 1'b0;
    end
  end

  // FSM state, event registers and registered strobe outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wcnt           <= '0;
      mw_q           <= MW_ONE;
      ho_cnt         <= '0;
      self_f         <= 1'b0;
      trig_pulse_q   <= 1'b0;
      trig_is_self_q <= 1'b0;
      trig_busy_q    <= 1'b0;
    end else begin
      state          <= state_nxt;
      wcnt           <= wcnt_nxt;
      mw_q           <= mw_nxt;
      ho_cnt         <= ho_nxt;
      self_f         <= self_nxt;
      trig_pulse_q   <= fire_entry & ~(self_nxt & bus.self_mask_en);
      // Classification is only presented alongside an emitted strobe.
      trig_is_self_q <= fire_entry & self_nxt & ~bus.self_mask_en;
      trig_busy_q    <= (state_nxt != S_IDLE);
    end
  end

  // Housekeeping counters; counted in FIRE even when the strobe is masked,
  // and a clear overrides any coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.cnt_clr) begin
      trig_count_q   <= '0;
      self_count_q   <= '0;
      glitch_count_q <= '0;
    end else begin
      if (state == S_FIRE) begin
        if (self_f) self_count_q <= self_count_q + CNT_ONE;
        else        trig_count_q <= trig_count_q + CNT_ONE;
      end
      if (glitch_inc && glitch_count_q != 16'hFFFF)
        glitch_count_q <= glitch_count_q + 16'd1;
    end
  end

`ifdef EXT_TRIG_TIMESTAMP_EN
  logic [47:0] ts_ctr, ts_q;

  // Free-running timebase; trig_ts captures it on every fire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_ctr <= '0;
      ts_q   <= '0;
    end else begin
      ts_ctr <= ts_ctr + 48'd1;
      if (fire_entry) ts_q <= ts_ctr;
    end
  end

  assign bus.trig_ts = ts_q;
`else
  assign bus.trig_ts = '0;
`endif

  assign bus.trig_pulse   = trig_pulse_q;
  assign bus.trig_is_self = trig_is_self_q;
  assign bus.trig_busy    = trig_busy_q;
  assign bus.trig_count   = trig_count_q;
  assign bus.self_count   = self_count_q;
  assign bus.glitch_count = glitch_count_q;

endmodule

// File: doc/ext_trig_cond.md
# ext_trig_cond

Conditions the shared external trigger line after the I/O buffer inverts it. The block takes the asynchronous `ext_trig_maroc` level and synchronises it to `clk`. It qualifies pulses by minimum width, classifies each event as self-originated or external using the local `pixel_trig_maroc` drive, and applies a programmable holdoff. Each accepted trigger becomes a single-cycle pulse for the acquisition logic, and the block keeps event counters for housekeeping readout.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops on `ext_trig_maroc`; legal range 2..4.
- `MW_W`, 8: width of `min_width`.
- `HO_W`, 16: width of `holdoff`.
- `CNT_W`, 32: width of `trig_count` and `self_count`.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `ext_trig_maroc` in 1: trigger line level, high = asserted; asynchronous to `clk`.
- `pixel_trig_maroc` in 1: local drive of the line; synchronous to `clk`.
- `trig_en` in 1: enables conditioning.
- `self_mask_en` in 1: when high, suppresses the pulse for self-originated events.
- `min_width` in MW_W: required high time, in clk cycles; 0 is treated as 1.
- `holdoff` in HO_W: dead time after a fire, in clk cycles.
- `cnt_clr` in 1: synchronous clear of all counters.
- `trig_pulse` out 1: one-cycle accepted-trigger strobe.
- `trig_is_self` out 1: event classification; valid while `trig_pulse` is high, 0 otherwise.
- `trig_busy` out 1: high in every state except IDLE.
- `trig_count` out CNT_W: count of external events accepted.
- `self_count` out CNT_W: count of self-originated events accepted.
- `glitch_count` out 16: count of pulses rejected for being shorter than `min_width`.
- `trig_ts` out 48: timestamp of the last fire (see Configuration).

## Operation
- **Synchroniser:** `ext_trig_maroc` passes through `SYNC_STAGES` flops to give `s`. `pixel_trig_maroc` is delayed by the same number of flops to give `p`, so both are aligned.
- **IDLE:**
  - `s`=1 and `trig_en`=1 → QUAL.
  - On entry to QUAL the block loads width counter = 1, latches `mw` = max(`min_width`,1), and latches `self_f` = `p`.
- **QUAL:**
  - Each cycle: `s`=1 → counter++; `self_f` |= `p`.
  - `s`=0 before the counter reaches `mw` → IDLE and `glitch_count`++ (saturates at 0xFFFF).
  - Counter == `mw` → FIRE.
- **FIRE (one cycle):**
  - `trig_pulse` = 1 unless (`self_f` & `self_mask_en`).
  - `trig_is_self` = `self_f`.
  - `self_f` → `self_count`++; otherwise `trig_count`++.
  - Counts increment even when the pulse is masked.
  - Next state: HOLDOFF, with `holdoff` latched.
- **HOLDOFF:** counts down the latched value; value 0 spends zero cycles here. Then → WAIT_LOW. Line activity in this state is ignored and not counted.
- **WAIT_LOW:** `s`=0 → IDLE. This guarantees exactly one fire per line assertion.
- **`trig_en` low:** forces IDLE on the next edge from any state. A FIRE already in progress still completes its single cycle.
- **Counter wrap:** `trig_count` and `self_count` wrap modulo 2^CNT_W.
- **`cnt_clr`:** zeroes all three counters. When it coincides with an increment, the clear wins.
- **Configuration inputs:** `min_width` and `holdoff` are sampled only at QUAL and HOLDOFF entry. Changes mid-event do not affect the event in progress.

## Timing
- **Reset values (rst_n=0 at an edge):**
  - State = IDLE; synchroniser flops = 0.
  - `trig_pulse`, `trig_is_self`, `trig_busy` = 0.
  - All counters = 0; `trig_ts` = 0.
- **Reset mid-event:** aborts the event with no count and no pulse.
- **Latency:** with edge 0 the first edge sampling `ext_trig_maroc` high and the line stable, `trig_pulse` is high in the cycle following edge `SYNC_STAGES + mw`. With defaults and `min_width`=1, that is after edge 3.
- **Minimum re-trigger period:** the next fire can occur no earlier than `holdoff` + 1 (WAIT_LOW) + `SYNC_STAGES` + `mw` cycles after the previous fire.
- **Output registration:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`EXT_TRIG_TIMESTAMP_EN` defined:**
  - A free-running 48-bit counter runs from reset and wraps at 2^48.
  - `trig_ts` is loaded with the counter value at the FIRE edge and is held until the next fire.
  - `cnt_clr` does not affect the counter or `trig_ts`.
- **`EXT_TRIG_TIMESTAMP_EN` undefined:** the counter is not instantiated and `trig_ts` is tied to 0.

## Test plan
- **External pulse:** `min_width`=4, `holdoff`=0, 10-cycle external pulse with `pixel_trig_maroc`=0 → exactly one `trig_pulse` after edge 6, `trig_is_self`=0, `trig_count`=1.
- **Glitch rejection:** `min_width`=4, pulses of 3 cycles ×5 → no `trig_pulse`, `glitch_count`=5, `trig_count`=0.
- **Self masking:** `pixel_trig_maroc` high for 8 cycles driving the line, `self_mask_en`=1 → no pulse, `self_count`=1. Repeat with `self_mask_en`=0 → pulse with `trig_is_self`=1.
- **Holdoff:** `holdoff`=100, second pulse starting 50 cycles after the first fire → ignored. Third pulse at 200 cycles → accepted, `trig_count`=2.
- **Abort and clear:** deassert `trig_en` during QUAL → IDLE with no count. Assert `cnt_clr` in the FIRE cycle → all counters read 0 afterwards.
- **Timestamp (`EXT_TRIG_TIMESTAMP_EN` defined):** two fires 1000 cycles apart → difference of the two `trig_ts` values = 1000.
